// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic phase sequencer and its helpers.
//   state_e      : FSM state encoding, also driven out on the phase port
//   LAMP_*       : {red, yellow, green} lamp codes
//   next_phase() : fixed phase rotation (sensor gating handled by the caller)
//   ns_lamp() / ew_lamp() : lamp decode per state
package traffic_pkg;

  typedef enum logic [2:0] {
    ST_ALLRED_A  = 3'd0,
    ST_NS_GREEN  = 3'd1,
    ST_NS_YELLOW = 3'd2,
    ST_ALLRED_B  = 3'd3,
    ST_EW_GREEN  = 3'd4,
    ST_EW_YELLOW = 3'd5,
    ST_FLASH     = 3'd6
  } state_e;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  function automatic state_e next_phase(state_e s);
    state_e n;
    case (s)
      ST_ALLRED_A:  n = ST_NS_GREEN;
      ST_NS_GREEN:  n = ST_NS_YELLOW;
      ST_NS_YELLOW: n = ST_ALLRED_B;
      ST_ALLRED_B:  n = ST_EW_GREEN;
      ST_EW_GREEN:  n = ST_EW_YELLOW;
      default:      n = ST_ALLRED_A;
    endcase
    return n;
  endfunction

  // flash_on selects the lit half of the night flash pattern.
  function automatic logic [2:0] ns_lamp(state_e s, logic flash_on);
    logic [2:0] l;
    case (s)
      ST_NS_GREEN:  l = LAMP_GRN;
      ST_NS_YELLOW: l = LAMP_YEL;
      ST_FLASH:     l = flash_on ? LAMP_YEL : LAMP_OFF;
      default:      l = LAMP_RED;
    endcase
    return l;
  endfunction

  function automatic logic [2:0] ew_lamp(state_e s, logic flash_on);
    logic [2:0] l;
    case (s)
      ST_EW_GREEN:  l = LAMP_GRN;
      ST_EW_YELLOW: l = LAMP_YEL;
      ST_FLASH:     l = flash_on ? LAMP_RED : LAMP_OFF;
      default:      l = LAMP_RED;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_phase_sequencer_if.sv
// Signal bundle between the sequencer and its environment.
//   slowclk   : divided-clock level (data, not a clock)
//   ew_sensor : EW vehicle waiting (level)
//   night     : night flash request, present only with TRAFFIC_NIGHT_FLASH_EN
//   ns_light, ew_light : {red, yellow, green} lamps
//   phase     : FSM state encoding
//   tick      : one-cycle strobe per slowclk rising edge
// master = environment side, slave = sequencer side.
interface traffic_phase_sequencer_if;
  logic       slowclk;
  logic       ew_sensor;
`ifdef TRAFFIC_NIGHT_FLASH_EN
  logic       night;
`endif
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic [2:0] phase;
  logic       tick;

`ifdef TRAFFIC_NIGHT_FLASH_EN
  modport master (output slowclk, ew_sensor, night,
                  input  ns_light, ew_light, phase, tick);
  modport slave  (input  slowclk, ew_sensor, night,
                  output ns_light, ew_light, phase, tick);
`else
  modport master (output slowclk, ew_sensor,
                  input  ns_light, ew_light, phase, tick);
  modport slave  (input  slowclk, ew_sensor,
                  output ns_light, ew_light, phase, tick);
`endif
endinterface

// File: rtl/tick_gen.sv
// Turns an asynchronous slow level into single-cycle strobes in the clk domain.
//   clk     : system clock
//   reset   : async active-low reset
//   slow_in : slow level, treated as asynchronous data
//   tick    : registered one-cycle pulse, 3 clk after each slow_in rise
// Falling edges of slow_in produce nothing.
module tick_gen (
  input  logic clk,
  input  logic reset,
  input  logic slow_in,
  output logic tick
);

  logic sync1_q, sync2_q, sync3_q;
  logic tick_d, tick_q;

  always_comb begin
    tick_d = sync2_q & ~sync3_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      sync1_q <= slow_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Two-road (NS/EW) traffic-light phase sequencer timed by slowclk ticks.
//   clk   : system clock
//   reset : async active-low reset
//   bus   : traffic_phase_sequencer_if.slave (slowclk, ew_sensor, lamps, phase, tick)
// Optional build macro TRAFFIC_NIGHT_FLASH_EN adds the night input and the FLASH state.
//
// state        | meaning
// ALLRED_A (0) | clearance before NS green
// NS_GREEN (1) | NS go; holds past minimum until EW traffic waits
// NS_YELLOW(2) | NS clearing
// ALLRED_B (3) | clearance before EW green
// EW_GREEN (4) | EW go
// EW_YELLOW(5) | EW clearing
// FLASH    (6) | night flash (macro build only, otherwise illegal)
module traffic_phase_sequencer
  import traffic_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int T_NS_GREEN = 30,
  parameter int T_EW_GREEN = 20,
  parameter int T_YELLOW   = 5,
  parameter int T_ALLRED   = 2
) (
  input logic                     clk,
  input logic                     reset,
  traffic_phase_sequencer_if.slave bus
);

  logic             tick;
  logic             ew_sync1_q, ew_sync_q;
  state_e           state_q, state_d, nxt;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       ns_light_q, ns_light_d, ew_light_q, ew_light_d;
`ifdef TRAFFIC_NIGHT_FLASH_EN
  logic             night_sync1_q, night_sync_q;
  logic             flash_q, flash_d;
`endif

  function automatic logic [CNT_W-1:0] dur_m1(state_e s);
    logic [CNT_W-1:0] d;
    case (s)
      ST_NS_GREEN:                d = CNT_W'(T_NS_GREEN - 1);
      ST_EW_GREEN:                d = CNT_W'(T_EW_GREEN - 1);
      ST_NS_YELLOW, ST_EW_YELLOW: d = CNT_W'(T_YELLOW - 1);
      default:                    d = CNT_W'(T_ALLRED - 1);
    endcase
    return d;
  endfunction

  tick_gen u_tick_gen (
    .clk     (clk),
    .reset   (reset),
    .slow_in (bus.slowclk),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ew_sync1_q <= 1'b0;
      ew_sync_q  <= 1'b0;
`ifdef TRAFFIC_NIGHT_FLASH_EN
      night_sync1_q <= 1'b0;
      night_sync_q  <= 1'b0;
`endif
    end else begin
      ew_sync1_q <= bus.ew_sensor;
      ew_sync_q  <= ew_sync1_q;
`ifdef TRAFFIC_NIGHT_FLASH_EN
      night_sync1_q <= bus.night;
      night_sync_q  <= night_sync1_q;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nxt     = next_phase(state_q);
`ifdef TRAFFIC_NIGHT_FLASH_EN
    flash_d = flash_q;
`endif
    case (state_q)
      ST_ALLRED_A, ST_NS_GREEN, ST_NS_YELLOW,
      ST_ALLRED_B, ST_EW_GREEN, ST_EW_YELLOW: begin
`ifdef TRAFFIC_NIGHT_FLASH_EN
        if (tick && night_sync_q) begin
          state_d = ST_FLASH;
          flash_d = 1'b1;
        end else
`endif
        if (tick) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if (!(state_q == ST_NS_GREEN && !ew_sync_q)) begin
            // NS_GREEN without a waiting EW vehicle keeps counter at 0 and
            // re-checks the sensor on every later tick.
            state_d = nxt;
            cnt_d   = dur_m1(nxt);
          end
        end
      end
`ifdef TRAFFIC_NIGHT_FLASH_EN
      ST_FLASH: begin
        if (tick) begin
          if (night_sync_q) begin
            flash_d = ~flash_q;
          end else begin
            state_d = ST_ALLRED_A;
            cnt_d   = dur_m1(ST_ALLRED_A);
            flash_d = 1'b0;
          end
        end
      end
`endif
      default: begin
        state_d = ST_ALLRED_A;
        cnt_d   = dur_m1(ST_ALLRED_A);
      end
    endcase

    // Lamps decode the next state so they switch on the same edge as state_q.
`ifdef TRAFFIC_NIGHT_FLASH_EN
    ns_light_d = ns_lamp(state_d, flash_d);
    ew_light_d = ew_lamp(state_d, flash_d);
`else
    ns_light_d = ns_lamp(state_d, 1'b1);
    ew_light_d = ew_lamp(state_d, 1'b1);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_ALLRED_A;
      cnt_q      <= CNT_W'(T_ALLRED - 1);
      ns_light_q <= LAMP_RED;
      ew_light_q <= LAMP_RED;
`ifdef TRAFFIC_NIGHT_FLASH_EN
      flash_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ns_light_q <= ns_light_d;
      ew_light_q <= ew_light_d;
`ifdef TRAFFIC_NIGHT_FLASH_EN
      flash_q    <= flash_d;
`endif
    end
  end

  assign bus.ns_light = ns_light_q;
  assign bus.ew_light = ew_light_q;
  assign bus.phase    = state_q;
  assign bus.tick     = tick;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
module tb_traffic_phase_sequencer;

  localparam int CNT_W      = 8;
  localparam int T_NS_GREEN = 30;
  localparam int T_EW_GREEN = 20;
  localparam int T_YELLOW   = 5;
  localparam int T_ALLRED   = 2;

  // Reference model: phase index, ticks spent in it, per-phase durations and lamps.
  localparam int         DUR    [6] = '{T_ALLRED, T_NS_GREEN, T_YELLOW, T_ALLRED, T_EW_GREEN, T_YELLOW};
  localparam logic [2:0] NS_TAB [6] = '{3'b100, 3'b001, 3'b010, 3'b100, 3'b100, 3'b100};
  localparam logic [2:0] EW_TAB [6] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b010};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  traffic_phase_sequencer_if bus_if ();

  traffic_phase_sequencer #(
    .CNT_W      (CNT_W),
    .T_NS_GREEN (T_NS_GREEN),
    .T_EW_GREEN (T_EW_GREEN),
    .T_YELLOW   (T_YELLOW),
    .T_ALLRED   (T_ALLRED)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int checks = 0;
  int errors = 0;
  int rises = 0;
  int tick_seen = 0;
  int m_idx = 0;
  int m_spent = 0;
  logic [8:0] exp_q[$];
  bit cmp_next = 0;
  bit tick_prev = 0;

  task automatic model_tick(input bit ew);
    m_spent++;
    if (m_spent >= DUR[m_idx]) begin
      if (m_idx == 1 && !ew) m_spent = DUR[1];
      else begin
        m_idx = (m_idx + 1) % 6;
        m_spent = 0;
      end
    end
    exp_q.push_back({3'(m_idx), NS_TAB[m_idx], EW_TAB[m_idx]});
  endtask

  task automatic do_tick(input int hi, input int lo);
    @(negedge clk);
    bus_if.slowclk = 1'b1;
    rises++;
    model_tick(bus_if.ew_sensor);
    repeat (hi) @(negedge clk);
    bus_if.slowclk = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic rand_tick();
    do_tick($urandom_range(4, 8), $urandom_range(4, 8));
  endtask

  // Monitor: safety every cycle, tick width, and a scoreboard compare on the
  // cycle after each tick (when the FSM has consumed it).
  always @(negedge clk) begin
    logic [8:0] exp_v, got_v;
    if (!reset) begin
      cmp_next = 0;
      tick_prev = 0;
    end else begin
      checks++;
      if (bus_if.ns_light != 3'b100 && bus_if.ew_light != 3'b100) begin
        errors++;
        $display("FAIL safety: ns=%b ew=%b, need at least one road red", bus_if.ns_light, bus_if.ew_light);
      end
      if (cmp_next) begin
        checks++;
        got_v = {bus_if.phase, bus_if.ns_light, bus_if.ew_light};
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_tick: phase/ns/ew=%b with nothing expected", got_v);
        end else begin
          exp_v = exp_q.pop_front();
          if (got_v !== exp_v) begin
            errors++;
            $display("FAIL phase_step: got phase=%0d ns=%b ew=%b expected phase=%0d ns=%b ew=%b",
                     got_v[8:6], got_v[5:3], got_v[2:0], exp_v[8:6], exp_v[5:3], exp_v[2:0]);
          end
        end
      end
      cmp_next = bus_if.tick;
      if (bus_if.tick) begin
        tick_seen++;
        checks++;
        if (tick_prev) begin
          errors++;
          $display("FAIL tick_width: tick high %0d consecutive cycles, required 1", 2);
        end
      end
      tick_prev = bus_if.tick;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    bus_if.slowclk   = 1'b0;
    bus_if.ew_sensor = 1'b1;
`ifdef TRAFFIC_NIGHT_FLASH_EN
    bus_if.night     = 1'b0;
`endif
    reset = 1'b0;

    // Reset held with slowclk toggling.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus_if.slowclk = ~bus_if.slowclk;
      checks++;
      if ({bus_if.phase, bus_if.ns_light, bus_if.ew_light, bus_if.tick} !== {3'd0, 3'b100, 3'b100, 1'b0}) begin
        errors++;
        $display("FAIL reset_state: phase=%0d ns=%b ew=%b tick=%b expected 0/100/100/0",
                 bus_if.phase, bus_if.ns_light, bus_if.ew_light, bus_if.tick);
      end
    end
    bus_if.slowclk = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Tick latency: rise -> tick on the third cycle only; fall -> nothing.
    bus_if.slowclk = 1'b1;
    rises++;
    model_tick(bus_if.ew_sensor);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (bus_if.tick !== (k == 3)) begin
        errors++;
        $display("FAIL tick_latency: cycle %0d tick=%b expected %b", k, bus_if.tick, (k == 3));
      end
    end
    repeat (2) @(negedge clk);
    bus_if.slowclk = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (bus_if.tick !== 1'b0) begin
        errors++;
        $display("FAIL fall_no_tick: tick=%b expected 0", bus_if.tick);
      end
    end

    // Full cycles with EW traffic always present.
    bus_if.ew_sensor = 1'b1;
    for (int i = 0; i < 70; i++) rand_tick();

    // No EW traffic: NS green must hold well past its minimum.
    bus_if.ew_sensor = 1'b0;
    for (int i = 0; i < 80; i++) rand_tick();
    checks++;
    if (bus_if.phase !== 3'd1 || bus_if.ns_light !== 3'b001) begin
      errors++;
      $display("FAIL sensor_hold: phase=%0d ns=%b expected 1/001", bus_if.phase, bus_if.ns_light);
    end
    bus_if.ew_sensor = 1'b1;
    for (int i = 0; i < 40; i++) rand_tick();

    // Random sensor pattern.
    for (int i = 0; i < 150; i++) begin
      bus_if.ew_sensor = ($urandom_range(0, 3) != 0);
      rand_tick();
    end

    // Mid-phase reset during EW_GREEN after 7 ticks there.
    bus_if.ew_sensor = 1'b1;
    guard = 0;
    while (!(m_idx == 4 && m_spent == 7) && guard < 200) begin
      rand_tick();
      guard++;
    end
    checks++;
    if (!(m_idx == 4 && m_spent == 7)) begin
      errors++;
      $display("FAIL reach_ew_green: model phase=%0d spent=%0d expected 4/7", m_idx, m_spent);
    end
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({bus_if.phase, bus_if.ns_light, bus_if.ew_light, bus_if.tick} !== {3'd0, 3'b100, 3'b100, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: phase=%0d ns=%b ew=%b tick=%b expected 0/100/100/0",
               bus_if.phase, bus_if.ns_light, bus_if.ew_light, bus_if.tick);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_at_reset: %0d expected steps outstanding, required 0", exp_q.size());
    end
    exp_q.delete();
    m_idx = 0;
    m_spent = 0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 12; i++) rand_tick();

    // slowclk stuck high then low: one tick for the rise, then frozen.
    do_tick(40, 40);
    checks++;
    if (bus_if.phase !== 3'(m_idx) || bus_if.ns_light !== NS_TAB[m_idx] || bus_if.ew_light !== EW_TAB[m_idx]) begin
      errors++;
      $display("FAIL stuck_slowclk: phase=%0d ns=%b ew=%b expected %0d/%b/%b",
               bus_if.phase, bus_if.ns_light, bus_if.ew_light, m_idx, NS_TAB[m_idx], EW_TAB[m_idx]);
    end

    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_ticks: %0d expected steps never observed", exp_q.size());
    end
    checks++;
    if (tick_seen != rises) begin
      errors++;
      $display("FAIL tick_count: saw %0d ticks, expected %0d", tick_seen, rises);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
